// File: rtl/demux_write_arbiter_if.sv
// rtl/demux_write_arbiter_if.sv - requester/destination bundle for demux_write_arbiter
//
// Purpose: groups the requester handshake, the demultiplexer drive signals and
// the destination handshake of demux_write_arbiter into one interface.
// Ports carried:
//   req_valid   [NUM_REQ]                 requester i has a word pending
//   req_data    [NUM_REQ][WIDTH]          requester data words
//   req_index   [NUM_REQ][SELECT_WIDTH]   requester destination selects
//   req_ready   [NUM_REQ]                 one-hot accept back to requesters
//   demux_data  [WIDTH]                   registered word to the demultiplexer
//   demux_index [SELECT_WIDTH]            registered select to the demultiplexer
//   dest_valid  [2**SELECT_WIDTH]         one-hot valid per destination
//   dest_ready  [2**SELECT_WIDTH]         destination accepts the word
//   busy                                  output stage occupied
//   drop_err                              one-cycle pulse on a timeout drop
// Modports: slave = arbiter view, master = requester/destination view.

interface demux_write_arbiter_if #(
    parameter int WIDTH        = 8,
    parameter int SELECT_WIDTH = 3,
    parameter int NUM_REQ      = 4
);
    localparam int NUM_DEST = 1 << SELECT_WIDTH;

    logic [NUM_REQ-1:0]                   req_valid;
    logic [NUM_REQ-1:0][WIDTH-1:0]        req_data;
    logic [NUM_REQ-1:0][SELECT_WIDTH-1:0] req_index;
    logic [NUM_REQ-1:0]                   req_ready;
    logic [WIDTH-1:0]                     demux_data;
    logic [SELECT_WIDTH-1:0]              demux_index;
    logic [NUM_DEST-1:0]                  dest_valid;
    logic [NUM_DEST-1:0]                  dest_ready;
    logic                                 busy;
    logic                                 drop_err;

    modport slave (
        input  req_valid, req_data, req_index, dest_ready,
        output req_ready, demux_data, demux_index, dest_valid, busy, drop_err
    );

    modport master (
        output req_valid, req_data, req_index, dest_ready,
        input  req_ready, demux_data, demux_index, dest_valid, busy, drop_err
    );
endinterface

// File: rtl/demux_write_arbiter.sv
// rtl/demux_write_arbiter.sv - round-robin write arbiter in front of a shared demultiplexer
//
// Purpose: grants one of NUM_REQ requesters per cycle (round robin), captures
// its word and destination select into a one-entry output stage, and holds the
// demultiplexer inputs plus a one-hot dest_valid until the addressed
// destination raises its dest_ready. A drain and a new accept may share a
// cycle, giving one word per cycle back to back.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      demux_write_arbiter_if.slave (requester, demux and destination signals)
// Optional feature macro: DWA_TIMEOUT_EN - drops a word that has stalled for
// TIMEOUT cycles, pulses drop_err, and blocks acceptance in that pulse cycle.
// Without it the stage waits indefinitely and drop_err is tied low.

module demux_write_arbiter #(
    parameter int WIDTH        = 8,
    parameter int SELECT_WIDTH = 3,
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    demux_write_arbiter_if.slave  bus
);
    localparam int NUM_DEST = 1 << SELECT_WIDTH;
    localparam int GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2) begin : g_chk_num_req
        $error("demux_write_arbiter: NUM_REQ must be at least 2");
    end
    if (TIMEOUT < 1) begin : g_chk_timeout
        $error("demux_write_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_e;

    stage_e                  state_q, state_d;
    logic [WIDTH-1:0]        data_q, data_d;
    logic [SELECT_WIDTH-1:0] index_q, index_d;
    logic [GW-1:0]           last_grant_q, last_grant_d;

    logic                    drain;
    logic                    block_accept;
    logic                    accept_ok;
    logic                    grant_found;
    logic [GW-1:0]           grant_idx;
    logic [NUM_REQ-1:0]      grant_onehot;

`ifdef DWA_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] stall_q, stall_d;
    logic          drop_q, drop_d;
`endif

    // Only the currently addressed destination can drain the stage.
    assign drain = (state_q == ST_FULL) && bus.dest_ready[index_q];

`ifdef DWA_TIMEOUT_EN
    // The cycle that reports a drop is kept free of new grants.
    assign block_accept = drop_q;
`else
    assign block_accept = 1'b0;
`endif

    assign accept_ok = ((state_q == ST_EMPTY) || drain) && !block_accept;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && bus.req_valid[GW'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = GW'(cand);
            end
        end
    end

    // reset_n gates the grant so req_ready is low throughout reset.
    assign grant_onehot = (grant_found && accept_ok && reset_n)
                        ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        index_d      = index_q;
        last_grant_d = last_grant_q;
`ifdef DWA_TIMEOUT_EN
        stall_d      = stall_q;
        drop_d       = 1'b0;
`endif
        if (|grant_onehot) begin
            // Covers both a plain fill and a simultaneous drain+refill.
            data_d       = bus.req_data[grant_idx];
            index_d      = bus.req_index[grant_idx];
            last_grant_d = grant_idx;
            state_d      = ST_FULL;
`ifdef DWA_TIMEOUT_EN
            stall_d      = '0;
`endif
        end else if (drain) begin
            // Data and select keep their last values once the stage empties.
            state_d = ST_EMPTY;
`ifdef DWA_TIMEOUT_EN
            stall_d = '0;
`endif
        end
`ifdef DWA_TIMEOUT_EN
        else if (state_q == ST_FULL) begin
            if (stall_q == CW'(TIMEOUT - 1)) begin
                state_d = ST_EMPTY;
                stall_d = '0;
                drop_d  = 1'b1;
            end else begin
                stall_d = stall_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_EMPTY;
            data_q       <= '0;
            index_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
`ifdef DWA_TIMEOUT_EN
            stall_q      <= '0;
            drop_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            index_q      <= index_d;
            last_grant_q <= last_grant_d;
`ifdef DWA_TIMEOUT_EN
            stall_q      <= stall_d;
            drop_q       <= drop_d;
`endif
        end
    end

    assign bus.req_ready   = grant_onehot;
    assign bus.demux_data  = data_q;
    assign bus.demux_index = index_q;
    assign bus.busy        = (state_q == ST_FULL);
    assign bus.dest_valid  = (state_q == ST_FULL) ? (NUM_DEST'(1) << index_q) : '0;
`ifdef DWA_TIMEOUT_EN
    assign bus.drop_err    = drop_q;
`else
    assign bus.drop_err    = 1'b0;
`endif

endmodule

// File: tb/tb_demux_write_arbiter.sv
// tb/tb_demux_write_arbiter.sv - self-checking bench for demux_write_arbiter

module tb_demux_write_arbiter;
    localparam int WIDTH = 8;
    localparam int SW    = 3;
    localparam int NR    = 4;
    localparam int ND    = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    demux_write_arbiter_if #(.WIDTH(WIDTH), .SELECT_WIDTH(SW), .NUM_REQ(NR)) bus ();

    demux_write_arbiter #(
        .WIDTH(WIDTH), .SELECT_WIDTH(SW), .NUM_REQ(NR), .TIMEOUT(15)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;
    int grants[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the output stage is either empty or holds one word;
    // the pointer remembers the last winner.
    bit              m_full = 1'b0;
    logic [WIDTH-1:0] m_data = '0;
    logic [SW-1:0]    m_idx  = '0;
    int               m_ptr  = NR - 1;

    // Winner = valid requester at the smallest circular distance after m_ptr.
    function automatic int pick();
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = NR;
        for (int i = 0; i < NR; i++) begin
            d = (i - m_ptr - 1 + 2 * NR) % NR;
            if (bus.req_valid[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int  g;
        bit  drn;
        if (!reset_n) begin
            m_full <= 1'b0;
            m_data <= '0;
            m_idx  <= '0;
            m_ptr  <= NR - 1;
        end else begin
            g   = pick();
            drn = m_full && bus.dest_ready[m_idx];
            if (g >= 0 && (!m_full || drn)) begin
                m_data <= bus.req_data[g];
                m_idx  <= bus.req_index[g];
                m_ptr  <= g;
                m_full <= 1'b1;
            end else if (drn) begin
                m_full <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        logic [NR-1:0] er;
        int            g;
        g  = pick();
        er = (reset_n && g >= 0 && (!m_full || bus.dest_ready[m_idx])) ? (NR'(1) << g) : '0;
        check("req_ready", 32'(bus.req_ready), 32'(er));
        check("busy", 32'(bus.busy), 32'(m_full));
        check("dest_valid", 32'(bus.dest_valid), m_full ? (32'h1 << m_idx) : 32'h0);
        check("demux_data", 32'(bus.demux_data), 32'(m_data));
        check("demux_index", 32'(bus.demux_index), 32'(m_idx));
`ifndef DWA_TIMEOUT_EN
        check("drop_err", 32'(bus.drop_err), 32'h0);
`endif
        if (|(bus.req_ready & bus.req_valid)) begin
            for (int i = 0; i < NR; i++) begin
                if (bus.req_ready[i]) grants.push_back(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grants(input string name, input int exp[], input int n);
        check({name, "_count"}, 32'(grants.size()), 32'(n));
        for (int i = 0; i < n && i < grants.size(); i++) begin
            check($sformatf("%s_%0d", name, i), 32'(grants[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        int exp2[] = '{1, 2, 3, 0, 1, 2};
        int exp3[] = '{3, 0};
        int exp4[] = '{3, 1, 3};
        int exp5[] = '{0};

        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.req_index  = '0;
        bus.dest_ready = '1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_dest_valid", 32'(bus.dest_valid), 32'h0);
        check("rst_demux_data", 32'(bus.demux_data), 32'h0);
        reset_n = 1'b1;

        // Single word 0xA5 to destination 5
        bus.req_valid    = 4'b0001;
        bus.req_data[0]  = 8'hA5;
        bus.req_index[0] = 3'd5;
        #1;
        check("t1_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        check("t1_data", 32'(bus.demux_data), 32'hA5);
        check("t1_index", 32'(bus.demux_index), 32'h5);
        check("t1_dest_valid", 32'(bus.dest_valid), 32'h20);
        check("t1_busy", 32'(bus.busy), 32'h1);
        step();
        check("t1_busy_after", 32'(bus.busy), 32'h0);

        // All four requesters continuously valid: rotation from pointer 0
        grants.delete();
        for (int i = 0; i < NR; i++) begin
            bus.req_data[i]  = 8'h10 + 8'(i);
            bus.req_index[i] = 3'(i);
        end
        bus.req_valid = 4'b1111;
        repeat (6) step();
        bus.req_valid = '0;
        check_grants("t2_grant", exp2, 6);
        check("t2_last_data", 32'(bus.demux_data), 32'h12);

        // Stall on destination 2 while the others are ready
        step();
        grants.delete();
        bus.dest_ready   = 8'hFB;
        bus.req_valid    = 4'b1000;
        bus.req_data[3]  = 8'h33;
        bus.req_index[3] = 3'd2;
        step();
        bus.req_valid    = 4'b0001;
        bus.req_data[0]  = 8'h44;
        bus.req_index[0] = 3'd6;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t3_stall_dest_valid", 32'(bus.dest_valid), 32'h04);
            check("t3_stall_ready", 32'(bus.req_ready), 32'h0);
            step();
        end
        bus.dest_ready = 8'hFF;
        #1;
        check("t3_release_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        check("t3_next_data", 32'(bus.demux_data), 32'h44);
        check("t3_next_index", 32'(bus.demux_index), 32'h6);
        check_grants("t3_grant", exp3, 2);

        // Wrap: 3 alone, then 1 and 3 together
        step();
        grants.delete();
        bus.req_index[3] = 3'd1;
        bus.req_index[1] = 3'd4;
        bus.req_data[1]  = 8'h11;
        bus.dest_ready   = 8'h10;
        bus.req_valid    = 4'b1000;
        step();
        bus.dest_ready   = 8'h12;
        bus.req_valid    = 4'b1010;
        step();
        step();
        bus.req_valid = '0;
        check_grants("t4_grant", exp4, 3);

        // Asynchronous reset while the stage is full
        step();
        step();
        grants.delete();
        bus.dest_ready   = '0;
        bus.req_valid    = 4'b0100;
        bus.req_data[2]  = 8'h5A;
        bus.req_index[2] = 3'd7;
        step();
        bus.req_valid = '0;
        #1;
        check("t5_busy_pre", 32'(bus.busy), 32'h1);
        check("t5_data_pre", 32'(bus.demux_data), 32'h5A);
        #1;
        reset_n       = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        check("t5_busy_rst", 32'(bus.busy), 32'h0);
        check("t5_dest_valid_rst", 32'(bus.dest_valid), 32'h0);
        check("t5_data_rst", 32'(bus.demux_data), 32'h0);
        check("t5_ready_rst", 32'(bus.req_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        grants.delete();
        reset_n        = 1'b1;
        bus.dest_ready = 8'hFF;
        step();
        bus.req_valid = '0;
        check_grants("t5_grant", exp5, 1);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/demux_write_arbiter.md
Name: demux_write_arbiter

Overview:
- Round-robin arbiter and sequencer in front of the shared WIDTH-bit demultiplexer datapath.
- NUM_REQ requesters each offer a data word plus a destination select. The block grants one requester at a time and captures its word and select into a one-entry output stage.
- It drives the demultiplexer's data/select inputs and a one-hot per-destination valid, then holds them until the addressed destination acknowledges.
- Used to share the cell-write fan-out between maze-generation engines.

Parameters:
- WIDTH, 8, data word width (matches demultiplexer WIDTH).
- SELECT_WIDTH, 3, destination select width; 2**SELECT_WIDTH destinations.
- NUM_REQ, 4, number of requesters (>=2).
- TIMEOUT, 15, stall-cycle limit; used only with DWA_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  [NUM_REQ]  requester i has a word pending.
- req_data  input  [NUM_REQ][WIDTH]  requester data words.
- req_index  input  [NUM_REQ][SELECT_WIDTH]  requester destination selects.
- req_ready  output  [NUM_REQ]  one-hot accept; a transfer occurs when req_valid[i] && req_ready[i].
- demux_data  output  WIDTH  registered word to the demultiplexer data input.
- demux_index  output  SELECT_WIDTH  registered select to the demultiplexer index input.
- dest_valid  output  [2**SELECT_WIDTH]  one-hot: the word on demux_data is valid for that destination.
- dest_ready  input  [2**SELECT_WIDTH]  destination accepts the word.
- busy  output  1  output stage occupied.
- drop_err  output  1  one-cycle pulse on timeout drop (tied 0 without DWA_TIMEOUT_EN).

Behaviour:
- Reset (async assert, sync-safe deassert):
  - demux_data=0, demux_index=0, dest_valid=0, busy=0, drop_err=0.
  - req_ready=0 while reset_n low.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
- Output stage states:
  - EMPTY (busy=0): dest_valid all zero.
  - FULL (busy=1): dest_valid = one-hot decode of demux_index.
- Drain: in FULL, when dest_ready[demux_index]=1 the word is delivered at that clock edge. Only dest_ready of the selected destination matters; the others are ignored.
- Accept condition: stage EMPTY, or stage FULL and draining this cycle.
- Arbitration (combinational, same cycle):
  - Search req_valid starting at (last_grant+1) mod NUM_REQ and wrap around.
  - The first valid requester g gets req_ready[g]=1 only if the accept condition holds; otherwise req_ready is all zero.
  - req_ready never depends on dest_ready of a destination other than the current demux_index.
- On a transfer edge: demux_data<=req_data[g], demux_index<=req_index[g], last_grant<=g, stage becomes FULL.
  - If a drain and an accept happen together, the stage stays FULL with the new word. This gives back-to-back throughput of 1 word/cycle.
- Latency: an accepted word appears on the demultiplexer inputs with dest_valid asserted the cycle after acceptance.
- If no request is valid and the stage drains, it goes EMPTY. last_grant is unchanged and demux_data/demux_index hold their last values.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.
- Requesters must hold req_data and req_index stable while req_valid is high and not yet accepted. Dropping req_valid before acceptance is allowed.
- Reset mid-transfer: the word is discarded, all outputs return to reset values, and the round-robin pointer resets.

Optional Feature:
- Macro: DWA_TIMEOUT_EN.
- Enabled:
  - A stall counter clears on each accept and increments each FULL cycle without a drain.
  - When it reaches TIMEOUT, the word is dropped: the stage goes EMPTY and drop_err pulses for 1 cycle.
  - Acceptance that same cycle is blocked, and the next grant occurs the following cycle.
- Disabled: no counter; the stage waits indefinitely; drop_err is constant 0.

Test Plan:
- Reset, then req_valid[0]=1 with data 0xA5, index 5, dest_ready all 1 -> req_ready[0]=1 in cycle 0; cycle 1: demux_data=0xA5, demux_index=5, dest_valid=8'b0010_0000, busy=1; cycle 2: busy=0.
- All four requesters valid continuously, all dest_ready=1 -> grant order 0,1,2,3,0,1, one word per cycle, no bubbles.
- Word to index 2 with dest_ready[2]=0 for 3 cycles while dest_ready[other]=1 -> dest_valid held at 8'b0000_0100, req_ready stays 0; on cycle dest_ready[2]=1 the next requester is accepted simultaneously.
- Requester 3 granted last, then only requesters 1 and 3 valid -> next grant 1, then 3 (wrap from pointer 3 to 0 to 1).
- reset_n pulsed low asynchronously while FULL -> dest_valid, busy, demux_data drop to 0 immediately; after release requester 0 wins first.
- With DWA_TIMEOUT_EN, TIMEOUT=15, dest_ready held 0 -> on the 15th stalled cycle drop_err=1 for one cycle, busy=0, the next request is granted the following cycle.
